// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: bus width, NOP encoding, FSM states.
package inst_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;
endpackage

// File: rtl/fetch_timer.sv
// WAIT-phase cycle counter; expired marks the last WAIT cycle before a timeout.
module fetch_timer #(
  parameter int unsigned W     = 8,
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) cnt <= '0;
    else if (enable)  cnt <= cnt + 1'b1;
  end

  // Fires during the LIMIT-th waiting cycle so the fault lands exactly LIMIT cycles after entry.
  assign expired = enable && (cnt == W'(LIMIT - 1));
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding memory read, misalignment/error/timeout faults,
// and redirect-while-busy handled by dropping the in-flight result.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned     TIMEOUT_CYCLES = 255,
  parameter logic [XLEN-1:0] NOP_INST       = NOP
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            fetch_en,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  output logic            fault,
  output logic            busy,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            mem_rsp_err
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e          state, state_nxt;
  logic [XLEN-1:0] pend_pc;
  logic            discard;
  logic            expired;
  logic            done;
  logic            redo;
  logic [XLEN-1:0] redo_pc;

  fetch_timer #(.W(TW), .LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != S_WAIT),
    .enable  (state == S_WAIT),
    .expired (expired)
  );

  // A redirect arriving in the same cycle as completion wins over the stored pending pc.
  assign done    = (state == S_WAIT) && (mem_rsp_valid || expired);
  assign redo    = discard || fetch_en;
  assign redo_pc = fetch_en ? pc : pend_pc;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (fetch_en && pc[1:0] == 2'b00) state_nxt = S_REQ;
      S_REQ:   if (mem_req_ready) state_nxt = S_WAIT;
      S_WAIT:  if (done) state_nxt = (redo && redo_pc[1:0] == 2'b00) ? S_REQ : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state != S_IDLE);
    mem_req_valid = (state == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst         <= NOP_INST;
      inst_valid   <= 1'b0;
      fault        <= 1'b0;
      mem_req_addr <= '0;
      pend_pc      <= '0;
      discard      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (fetch_en) begin
          if (pc[1:0] == 2'b00) begin
            mem_req_addr <= pc;
            inst_valid   <= 1'b0;
            fault        <= 1'b0;
          end else begin
            inst       <= NOP_INST;
            fault      <= 1'b1;
            inst_valid <= 1'b1;
          end
        end
        S_REQ: if (fetch_en) begin
          pend_pc <= pc;
          discard <= 1'b1;
        end
        S_WAIT: if (done) begin
          discard <= 1'b0;
          if (!redo) begin
            inst       <= (mem_rsp_valid && !mem_rsp_err) ? mem_rsp_data : NOP_INST;
            fault      <= !mem_rsp_valid || mem_rsp_err;
            inst_valid <= 1'b1;
          end else if (redo_pc[1:0] == 2'b00) begin
            mem_req_addr <= redo_pc;
            inst_valid   <= 1'b0;
            fault        <= 1'b0;
          end else begin
            inst       <= NOP_INST;
            fault      <= 1'b1;
            inst_valid <= 1'b1;
          end
        end else if (fetch_en) begin
          pend_pc <= pc;
          discard <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench: directed fetch scenarios then randomized traffic against a behavioural model.
module tb_inst_fetch;
  localparam int          TO  = 4;
  localparam logic [31:0] NOPV = 32'h0000_0013;

  logic        clk, rst, fetch_en, mem_req_ready, mem_rsp_valid, mem_rsp_err;
  logic [31:0] pc, mem_rsp_data;
  logic [31:0] inst, mem_req_addr;
  logic        inst_valid, fault, busy, mem_req_valid;

  int checks = 0;
  int failures = 0;

  inst_fetch #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .pc(pc), .fetch_en(fetch_en),
    .inst(inst), .inst_valid(inst_valid), .fault(fault), .busy(busy),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0 = no fetch outstanding, 1 = request being offered, 2 = awaiting data.
  int          m_phase, m_age;
  logic [31:0] m_inst, m_addr, m_pend;
  bit          m_valid, m_fault, m_disc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_phase = 0; m_age = 0; m_inst = NOPV; m_addr = 0; m_pend = 0;
    m_valid = 0; m_fault = 0; m_disc = 0;
  endtask

  task automatic m_start(input logic [31:0] a);
    if (a[1:0] != 2'b00) begin
      m_inst = NOPV; m_fault = 1; m_valid = 1; m_phase = 0;
    end else begin
      m_addr = a; m_valid = 0; m_fault = 0; m_phase = 1;
    end
  endtask

  task automatic m_step();
    if (rst) begin m_reset(); return; end
    case (m_phase)
      0: if (fetch_en) m_start(pc);
      1: begin
        if (fetch_en) begin m_pend = pc; m_disc = 1; end
        if (mem_req_ready) begin m_phase = 2; m_age = 0; end
      end
      default: begin
        m_age++;
        if (mem_rsp_valid || m_age == TO) begin
          if (m_disc || fetch_en) m_start(fetch_en ? pc : m_pend);
          else begin
            m_inst  = (mem_rsp_valid && !mem_rsp_err) ? mem_rsp_data : NOPV;
            m_fault = !mem_rsp_valid || mem_rsp_err;
            m_valid = 1;
            m_phase = 0;
          end
          m_disc = 0;
        end else if (fetch_en) begin
          m_pend = pc; m_disc = 1;
        end
      end
    endcase
  endtask

  // Inputs are already driven; compare at the falling edge, advance the model, cross the rising edge.
  task automatic cycle();
    @(negedge clk);
    chk("inst", inst, m_inst);
    chk("inst_valid", 32'(inst_valid), 32'(m_valid));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("mem_req_valid", 32'(mem_req_valid), 32'(m_phase == 1));
    if (m_phase == 1) chk("mem_req_addr", mem_req_addr, m_addr);
    m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    fetch_en = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_err = 0; rst = 0;
  endtask

  initial begin
    rst = 1; pc = 0; mem_rsp_data = 0;
    fetch_en = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_err = 0;
    m_reset();
    @(posedge clk); #1;
    cycle();
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", mem_req_addr, 32'd0);

    // Minimum-latency fetch
    idle_in(); pc = 32'h8000_0000; fetch_en = 1; cycle();
    idle_in(); mem_req_ready = 1;
    chk("d1_req_valid", 32'(mem_req_valid), 32'd1);
    chk("d1_addr", mem_req_addr, 32'h8000_0000);
    cycle();
    idle_in(); mem_rsp_valid = 1; mem_rsp_data = 32'h0050_0093; cycle();
    idle_in();
    chk("d1_inst", inst, 32'h0050_0093);
    chk("d1_valid", 32'(inst_valid), 32'd1);
    chk("d1_fault", 32'(fault), 32'd0);

    // Misaligned pc: immediate fault, no request
    idle_in(); pc = 32'h8000_0002; fetch_en = 1; cycle();
    idle_in();
    chk("d2_req_valid", 32'(mem_req_valid), 32'd0);
    chk("d2_inst", inst, 32'h0000_0013);
    chk("d2_fault", 32'(fault), 32'd1);
    chk("d2_valid", 32'(inst_valid), 32'd1);

    // Back-pressure: request held stable for 5 cycles
    idle_in(); pc = 32'h8000_0010; fetch_en = 1; cycle();
    idle_in();
    for (int i = 0; i < 5; i++) begin
      chk("d3_req_valid", 32'(mem_req_valid), 32'd1);
      chk("d3_addr", mem_req_addr, 32'h8000_0010);
      cycle();
    end
    mem_req_ready = 1; cycle();
    idle_in(); mem_rsp_valid = 1; mem_rsp_data = 32'h1111_1111; cycle();
    idle_in();
    chk("d3_inst", inst, 32'h1111_1111);

    // Timeout after TO waiting cycles
    pc = 32'h8000_0020; fetch_en = 1; cycle();
    idle_in(); mem_req_ready = 1; cycle();
    idle_in();
    for (int i = 0; i < 3; i++) cycle();
    chk("d4_busy_before", 32'(busy), 32'd1);
    chk("d4_fault_before", 32'(fault), 32'd0);
    cycle();
    chk("d4_fault", 32'(fault), 32'd1);
    chk("d4_inst", inst, 32'h0000_0013);
    chk("d4_valid", 32'(inst_valid), 32'd1);

    // Redirect during WAIT drops the in-flight response
    pc = 32'h8000_0000; fetch_en = 1; cycle();
    idle_in(); mem_req_ready = 1; cycle();
    idle_in(); pc = 32'h8000_0004; fetch_en = 1; cycle();
    idle_in(); mem_rsp_valid = 1; mem_rsp_data = 32'hDEAD_BEEF; cycle();
    idle_in();
    chk("d5_valid_dropped", 32'(inst_valid), 32'd0);
    chk("d5_inst_kept", inst, 32'h0000_0013);
    chk("d5_req_valid", 32'(mem_req_valid), 32'd1);
    chk("d5_addr", mem_req_addr, 32'h8000_0004);
    mem_req_ready = 1; cycle();
    idle_in(); mem_rsp_valid = 1; mem_rsp_data = 32'h00A0_0113; cycle();
    idle_in();
    chk("d5_inst", inst, 32'h00A0_0113);
    chk("d5_valid", 32'(inst_valid), 32'd1);

    // Reset in WAIT, then a stale response
    pc = 32'h8000_0040; fetch_en = 1; cycle();
    idle_in(); mem_req_ready = 1; cycle();
    idle_in(); rst = 1; cycle();
    idle_in(); mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_F00D; cycle();
    idle_in();
    chk("d6_inst", inst, 32'h0000_0013);
    chk("d6_valid", 32'(inst_valid), 32'd0);
    chk("d6_fault", 32'(fault), 32'd0);
    chk("d6_busy", 32'(busy), 32'd0);
    chk("d6_addr", mem_req_addr, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 499) == 0);
      fetch_en      = ($urandom_range(0, 7) == 0);
      pc            = 32'h8000_0000 + 32'($urandom_range(0, 63)) * 4;
      if ($urandom_range(0, 7) == 0) pc = pc + 32'($urandom_range(1, 3));
      mem_req_ready = ($urandom_range(0, 1) == 1);
      mem_rsp_valid = ($urandom_range(0, 2) == 0);
      mem_rsp_err   = ($urandom_range(0, 7) == 0);
      mem_rsp_data  = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
